// File: rtl/sweep_sequencer_if.sv
// Host/DDS/detector-facing signal bundle for the sweep sequencer.
// The slave modport is the sequencer; master is whatever drives config and acks.
interface sweep_sequencer_if #(
  parameter int unsigned FWORD_W  = 32,
  parameter int unsigned NPTS_W   = 16,
  parameter int unsigned SETTLE_W = 24
);
  logic                start;
  logic                abort;
  logic [FWORD_W-1:0]  f_start;
  logic [FWORD_W-1:0]  f_step;
  logic [NPTS_W-1:0]   n_points;
  logic [SETTLE_W-1:0] settle_cycles;
  logic                meas_ack;

  logic [FWORD_W-1:0]  fword;
  logic                fword_wen;
  logic                meas_req;
  logic [NPTS_W-1:0]   point_idx;
  logic                busy;
  logic                done;
  logic                aborted;
  logic                err;

  modport master (
    output start, abort, f_start, f_step, n_points, settle_cycles, meas_ack,
    input  fword, fword_wen, meas_req, point_idx, busy, done, aborted, err
  );

  modport slave (
    input  start, abort, f_start, f_step, n_points, settle_cycles, meas_ack,
    output fword, fword_wen, meas_req, point_idx, busy, done, aborted, err
  );
endinterface

// File: rtl/sweep_sequencer.sv
// Frequency-sweep sequencer: steps the DDS word over n_points, settles, then handshakes one measurement per point.
// Define SWEEP_TIMEOUT_EN to build the measurement-ack timeout and the sticky err flag.
module sweep_sequencer #(
  parameter int unsigned FWORD_W        = 32,
  parameter int unsigned NPTS_W         = 16,
  parameter int unsigned SETTLE_W       = 24,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1200000
) (
  input  logic             clk,
  input  logic             rstn,
  sweep_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, MEAS, DONE} state_t;

  state_t              state_q, state_d;
  logic [FWORD_W-1:0]  fword_q, fword_d;
  logic [FWORD_W-1:0]  step_q, step_d;
  logic [NPTS_W-1:0]   idx_q, idx_d;
  logic [NPTS_W-1:0]   npts_q, npts_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic                fword_wen_q, fword_wen_d;
  logic                aborted_q, aborted_d;
  logic                tmo_fire;
  logic                last_pt;

  assign last_pt = (idx_q == npts_q - NPTS_W'(1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      fword_q     <= '0;
      step_q      <= '0;
      idx_q       <= '0;
      npts_q      <= '0;
      settle_q    <= '0;
      cnt_q       <= '0;
      fword_wen_q <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fword_q     <= fword_d;
      step_q      <= step_d;
      idx_q       <= idx_d;
      npts_q      <= npts_d;
      settle_q    <= settle_d;
      cnt_q       <= cnt_d;
      fword_wen_q <= fword_wen_d;
      aborted_q   <= aborted_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fword_d     = fword_q;
    step_d      = step_q;
    idx_d       = idx_q;
    npts_d      = npts_q;
    settle_d    = settle_q;
    cnt_d       = cnt_q;
    fword_wen_d = 1'b0;
    aborted_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          step_d   = bus.f_step;
          npts_d   = bus.n_points;
          settle_d = bus.settle_cycles;
          if (bus.n_points == '0) begin
            state_d = DONE;
          end else begin
            fword_d     = bus.f_start;
            fword_wen_d = 1'b1;
            idx_d       = '0;
            cnt_d       = bus.settle_cycles;
            state_d     = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = MEAS;
        end else begin
          cnt_d = cnt_q - SETTLE_W'(1);
        end
      end
      MEAS: begin
        if (bus.meas_ack) begin
          if (last_pt) begin
            state_d = DONE;
          end else begin
            fword_d     = fword_q + step_q;
            idx_d       = idx_q + NPTS_W'(1);
            fword_wen_d = 1'b1;
            cnt_d       = settle_q;
            state_d     = SETTLE;
          end
        end else if (tmo_fire) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides whatever the state logic chose, including an ack in the same cycle.
    if (bus.abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      fword_d     = fword_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      fword_wen_d = 1'b0;
      aborted_d   = 1'b1;
    end
  end

`ifdef SWEEP_TIMEOUT_EN
  logic [31:0] tmo_q;
  logic        err_q;

  // Counter is zero on the first MEAS cycle because it is held clear outside MEAS.
  assign tmo_fire = (state_q == MEAS) && (tmo_q == TIMEOUT_CYCLES - 32'd1)
                    && !bus.meas_ack && !bus.abort;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= (state_q == MEAS) ? tmo_q + 32'd1 : 32'd0;
      if ((state_q == IDLE) && bus.start) begin
        err_q <= 1'b0;
      end else if (tmo_fire) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tmo_fire       = 1'b0;
  assign bus.err        = 1'b0;
`endif

  assign bus.fword     = fword_q;
  assign bus.fword_wen = fword_wen_q;
  assign bus.meas_req  = (state_q == MEAS);
  assign bus.point_idx = idx_q;
  assign bus.busy      = (state_q == SETTLE) || (state_q == MEAS);
  assign bus.done      = (state_q == DONE);
  assign bus.aborted   = aborted_q;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Scoreboard bench for sweep_sequencer: expected strobes are queued from the config, observed strobes popped and compared.
// The timeout scenario is only built when SWEEP_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_sweep_sequencer;
  localparam int FW = 32;
  localparam int NW = 16;
  localparam int SW = 24;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sweep_sequencer_if #(.FWORD_W(FW), .NPTS_W(NW), .SETTLE_W(SW)) bus ();

  sweep_sequencer #(
    .FWORD_W(FW), .NPTS_W(NW), .SETTLE_W(SW), .TIMEOUT_CYCLES(32'd16)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [FW-1:0] exp_fw[$];
  int            exp_idx[$];
  int            exp_cyc[$];
  logic [FW-1:0] obs_fw[$];
  int            obs_idx[$];
  int            obs_wen[$];
  int            obs_req[$];
  int            obs_done[$];
  int            obs_abort[$];
  bit busy_seen, busy_before_done, busy_at_done, req_at_abort;
  bit err_first, err_at_abort, err_last, obs_timeout;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [FW-1:0] f0, input logic [FW-1:0] st,
                     input int n, input int s);
    bus.f_start       = f0;
    bus.f_step        = st;
    bus.n_points      = NW'(n);
    bus.settle_cycles = SW'(s);
  endtask

  // Reference model of the strobe sequence: word k, index k, cycle 1 + k*(settle + 2 + ack delay).
  task automatic push_pts(input logic [FW-1:0] f0, input logic [FW-1:0] st,
                          input int n, input int s, input int ack_dly);
    logic [FW-1:0] w;
    w = f0;
    for (int k = 0; k < n; k++) begin
      exp_fw.push_back(w);
      exp_idx.push_back(k);
      exp_cyc.push_back(1 + k * (s + 2 + ack_dly));
      w = w + st;
    end
  endtask

  // Pulses start, answers meas_req after ack_dly cycles, and records what the DUT does.
  task automatic observe(input int max_cyc, input int ack_dly, input int abort_pt, input int poke_cyc);
    int cyc = 0;
    int fin_cyc = -1;
    int req_age = 0;
    bit prev_req = 1'b0;
    bit prev_busy = 1'b0;
    obs_fw.delete(); obs_idx.delete(); obs_wen.delete(); obs_req.delete();
    obs_done.delete(); obs_abort.delete();
    busy_seen = 0; busy_before_done = 0; busy_at_done = 1; req_at_abort = 1; err_at_abort = 0;
    bus.start = 1'b1;
    while (cyc < max_cyc && (fin_cyc < 0 || cyc < fin_cyc + 4)) begin
      tick();
      cyc++;
      bus.start    = (cyc == poke_cyc);
      bus.abort    = 1'b0;
      bus.meas_ack = 1'b0;
      if (cyc == poke_cyc) bus.f_step = 32'd7;
      if (cyc == 1) err_first = bus.err;
      if (bus.busy) busy_seen = 1;
      if (bus.fword_wen) begin
        obs_fw.push_back(bus.fword);
        obs_idx.push_back(int'(bus.point_idx));
        obs_wen.push_back(cyc);
        $display("  cyc %0d: strobe idx=%0d fword=%h", cyc, bus.point_idx, bus.fword);
      end
      if (bus.meas_req && !prev_req) obs_req.push_back(cyc);
      if (bus.done) begin
        obs_done.push_back(cyc);
        busy_before_done = prev_busy;
        busy_at_done = bus.busy;
        if (fin_cyc < 0) fin_cyc = cyc;
        $display("  cyc %0d: done", cyc);
      end
      if (bus.aborted) begin
        obs_abort.push_back(cyc);
        req_at_abort = bus.meas_req;
        err_at_abort = bus.err;
        if (fin_cyc < 0) fin_cyc = cyc;
        $display("  cyc %0d: aborted err=%0b", cyc, bus.err);
      end
      req_age = bus.meas_req ? req_age + 1 : 0;
      if (bus.meas_req && req_age == ack_dly + 1) begin
        bus.meas_ack = 1'b1;
        if (int'(bus.point_idx) == abort_pt) bus.abort = 1'b1;
      end
      prev_req  = bus.meas_req;
      prev_busy = bus.busy;
    end
    bus.start = 1'b0; bus.abort = 1'b0; bus.meas_ack = 1'b0;
    err_last = bus.err;
    obs_timeout = (fin_cyc < 0);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) tick();
    vectors++;
    if (bus.fword !== '0) begin
      miscompares++; $display("FAIL reset_fword: got %h want 0", bus.fword);
    end
    vectors++;
    if (bus.point_idx !== '0) begin
      miscompares++; $display("FAIL reset_idx: got %0d want 0", bus.point_idx);
    end
    vectors++;
    if ({bus.fword_wen, bus.meas_req, bus.busy, bus.done, bus.aborted, bus.err} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got wen/req/busy/done/abt/err=%b want 000000",
               {bus.fword_wen, bus.meas_req, bus.busy, bus.done, bus.aborted, bus.err});
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [FW-1:0] ef, of;
    int ei, ec, oi, oc;
    cfg(32'd1000, 32'd250, 4, 3);
    push_pts(32'd1000, 32'd250, 4, 3, 2);
    observe(80, 2, -1, -1);
    vectors++;
    if (obs_timeout || obs_req.size() != 4) begin
      miscompares++; $display("FAIL basic_reqs: timeout=%0b reqs=%0d want 0/4", obs_timeout, obs_req.size());
    end
    for (int i = 0; i < obs_req.size() && i < obs_wen.size(); i++) begin
      vectors++;
      if (obs_req[i] - obs_wen[i] != 4) begin
        miscompares++; $display("FAIL basic_settle[%0d]: req-strobe gap %0d want 4", i, obs_req[i] - obs_wen[i]);
      end
    end
    while (exp_fw.size() > 0) begin
      ef = exp_fw.pop_front(); ei = exp_idx.pop_front(); ec = exp_cyc.pop_front();
      vectors++;
      if (obs_fw.size() == 0) begin
        miscompares++; $display("FAIL basic_strobe: missing, want fword=%h idx=%0d cyc=%0d", ef, ei, ec);
      end else begin
        of = obs_fw.pop_front(); oi = obs_idx.pop_front(); oc = obs_wen.pop_front();
        if (of !== ef || oi != ei || oc != ec) begin
          miscompares++;
          $display("FAIL basic_strobe: got %h/%0d@%0d want %h/%0d@%0d", of, oi, oc, ef, ei, ec);
        end
      end
    end
    vectors++;
    if (obs_fw.size() != 0) begin
      miscompares++; $display("FAIL basic_extra: %0d extra strobes want 0", obs_fw.size());
    end
    vectors++;
    if (obs_done.size() != 1 || obs_done[0] != 29 || obs_abort.size() != 0) begin
      miscompares++;
      $display("FAIL basic_done: dones=%0d first@%0d aborts=%0d want 1@29 0",
               obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1, obs_abort.size());
    end
    vectors++;
    if (!busy_before_done || busy_at_done) begin
      miscompares++; $display("FAIL basic_busy: before=%0b at_done=%0b want 1/0", busy_before_done, busy_at_done);
    end
  endtask

  task automatic test_zero_points();
    cfg(32'd555, 32'd1, 0, 2);
    observe(20, 0, -1, -1);
    vectors++;
    if (obs_done.size() != 1 || obs_done[0] != 1) begin
      miscompares++;
      $display("FAIL zero_done: dones=%0d first@%0d want 1@1", obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1);
    end
    vectors++;
    if (obs_fw.size() != 0 || obs_req.size() != 0 || busy_seen) begin
      miscompares++;
      $display("FAIL zero_quiet: strobes=%0d reqs=%0d busy_seen=%0b want 0/0/0", obs_fw.size(), obs_req.size(), busy_seen);
    end
  endtask

  task automatic test_wrap();
    logic [FW-1:0] ef, of;
    int ei, ec, oi, oc;
    cfg(32'hFFFFFF00, 32'h100, 2, 0);
    push_pts(32'hFFFFFF00, 32'h100, 2, 0, 0);
    observe(40, 0, -1, -1);
    for (int i = 0; i < obs_req.size() && i < obs_wen.size(); i++) begin
      vectors++;
      if (obs_req[i] - obs_wen[i] != 1) begin
        miscompares++; $display("FAIL wrap_settle[%0d]: req-strobe gap %0d want 1", i, obs_req[i] - obs_wen[i]);
      end
    end
    while (exp_fw.size() > 0) begin
      ef = exp_fw.pop_front(); ei = exp_idx.pop_front(); ec = exp_cyc.pop_front();
      vectors++;
      if (obs_fw.size() == 0) begin
        miscompares++; $display("FAIL wrap_strobe: missing, want fword=%h idx=%0d cyc=%0d", ef, ei, ec);
      end else begin
        of = obs_fw.pop_front(); oi = obs_idx.pop_front(); oc = obs_wen.pop_front();
        if (of !== ef || oi != ei || oc != ec) begin
          miscompares++;
          $display("FAIL wrap_strobe: got %h/%0d@%0d want %h/%0d@%0d", of, oi, oc, ef, ei, ec);
        end
      end
    end
    vectors++;
    if (obs_fw.size() != 0 || obs_done.size() != 1 || obs_done[0] != 5) begin
      miscompares++;
      $display("FAIL wrap_done: extra=%0d dones=%0d first@%0d want 0 1@5",
               obs_fw.size(), obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1);
    end
  endtask

  task automatic test_abort_restart();
    logic [FW-1:0] ef, of;
    int ei, ec, oi, oc;
    cfg(32'd5000, 32'd300, 3, 1);
    push_pts(32'd5000, 32'd300, 2, 1, 1);
    observe(60, 1, 1, -1);
    while (exp_fw.size() > 0) begin
      ef = exp_fw.pop_front(); ei = exp_idx.pop_front(); ec = exp_cyc.pop_front();
      vectors++;
      if (obs_fw.size() == 0) begin
        miscompares++; $display("FAIL abort_strobe: missing, want fword=%h idx=%0d cyc=%0d", ef, ei, ec);
      end else begin
        of = obs_fw.pop_front(); oi = obs_idx.pop_front(); oc = obs_wen.pop_front();
        if (of !== ef || oi != ei || oc != ec) begin
          miscompares++;
          $display("FAIL abort_strobe: got %h/%0d@%0d want %h/%0d@%0d", of, oi, oc, ef, ei, ec);
        end
      end
    end
    vectors++;
    if (obs_fw.size() != 0 || obs_done.size() != 0) begin
      miscompares++; $display("FAIL abort_after: strobes=%0d dones=%0d want 0/0", obs_fw.size(), obs_done.size());
    end
    vectors++;
    if (obs_abort.size() != 1 || obs_abort[0] != 9 || req_at_abort) begin
      miscompares++;
      $display("FAIL abort_pulse: aborts=%0d first@%0d req=%0b want 1@9 req=0",
               obs_abort.size(), (obs_abort.size() > 0) ? obs_abort[0] : -1, req_at_abort);
    end
    push_pts(32'd5000, 32'd300, 3, 1, 1);
    observe(60, 1, -1, -1);
    while (exp_fw.size() > 0) begin
      ef = exp_fw.pop_front(); ei = exp_idx.pop_front(); ec = exp_cyc.pop_front();
      vectors++;
      if (obs_fw.size() == 0) begin
        miscompares++; $display("FAIL restart_strobe: missing, want fword=%h idx=%0d cyc=%0d", ef, ei, ec);
      end else begin
        of = obs_fw.pop_front(); oi = obs_idx.pop_front(); oc = obs_wen.pop_front();
        if (of !== ef || oi != ei || oc != ec) begin
          miscompares++;
          $display("FAIL restart_strobe: got %h/%0d@%0d want %h/%0d@%0d", of, oi, oc, ef, ei, ec);
        end
      end
    end
    vectors++;
    if (obs_done.size() != 1 || obs_done[0] != 13 || obs_abort.size() != 0) begin
      miscompares++;
      $display("FAIL restart_done: dones=%0d first@%0d aborts=%0d want 1@13 0",
               obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1, obs_abort.size());
    end
  endtask

  task automatic test_midsweep_ignore();
    logic [FW-1:0] ef, of;
    int ei, ec, oi, oc;
    cfg(32'd2000, 32'd10, 4, 2);
    push_pts(32'd2000, 32'd10, 4, 2, 1);
    observe(80, 1, -1, 3);
    while (exp_fw.size() > 0) begin
      ef = exp_fw.pop_front(); ei = exp_idx.pop_front(); ec = exp_cyc.pop_front();
      vectors++;
      if (obs_fw.size() == 0) begin
        miscompares++; $display("FAIL ignore_strobe: missing, want fword=%h idx=%0d cyc=%0d", ef, ei, ec);
      end else begin
        of = obs_fw.pop_front(); oi = obs_idx.pop_front(); oc = obs_wen.pop_front();
        if (of !== ef || oi != ei || oc != ec) begin
          miscompares++;
          $display("FAIL ignore_strobe: got %h/%0d@%0d want %h/%0d@%0d", of, oi, oc, ef, ei, ec);
        end
      end
    end
    vectors++;
    if (obs_fw.size() != 0 || obs_done.size() != 1 || obs_done[0] != 21) begin
      miscompares++;
      $display("FAIL ignore_done: extra=%0d dones=%0d first@%0d want 0 1@21",
               obs_fw.size(), obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1);
    end
  endtask

  task automatic test_start_abort_idle();
    cfg(32'd42, 32'd1, 2, 5);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1 || bus.fword_wen !== 1'b1 || bus.aborted !== 1'b0 || bus.fword !== 32'd42) begin
      miscompares++;
      $display("FAIL idle_abort_start: busy=%0b wen=%0b abt=%0b fword=%h want 1/1/0/0000002a",
               bus.busy, bus.fword_wen, bus.aborted, bus.fword);
    end
    tick();
    bus.abort = 1'b0;
    vectors++;
    if (bus.aborted !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL settle_abort: abt=%0b busy=%0b done=%0b want 1/0/0", bus.aborted, bus.busy, bus.done);
    end
    tick();
    vectors++;
    if (bus.aborted !== 1'b0) begin
      miscompares++; $display("FAIL abort_width: aborted=%0b want 0", bus.aborted);
    end
  endtask

  task automatic test_reset_midsweep();
    cfg(32'd100, 32'd1, 3, 2);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    rstn = 1'b0;
    tick();
    vectors++;
    if (bus.fword !== '0 || bus.point_idx !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.aborted !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset: fword=%h idx=%0d busy=%0b done=%0b abt=%0b want 0/0/0/0/0",
               bus.fword, bus.point_idx, bus.busy, bus.done, bus.aborted);
    end
    rstn = 1'b1;
    tick();
    vectors++;
    if (bus.done !== 1'b0 || bus.aborted !== 1'b0 || bus.fword_wen !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_after: done=%0b abt=%0b wen=%0b want 0/0/0", bus.done, bus.aborted, bus.fword_wen);
    end
  endtask

`ifdef SWEEP_TIMEOUT_EN
  task automatic test_timeout();
    cfg(32'd77, 32'd1, 2, 0);
    observe(60, 10000, -1, -1);
    vectors++;
    if (obs_abort.size() != 1 || obs_abort[0] != 18 || obs_done.size() != 0 || obs_fw.size() != 1) begin
      miscompares++;
      $display("FAIL timeout_abort: aborts=%0d first@%0d dones=%0d strobes=%0d want 1@18 0 1",
               obs_abort.size(), (obs_abort.size() > 0) ? obs_abort[0] : -1, obs_done.size(), obs_fw.size());
    end
    vectors++;
    if (!err_at_abort || !err_last) begin
      miscompares++; $display("FAIL timeout_err: at_abort=%0b later=%0b want 1/1", err_at_abort, err_last);
    end
    observe(60, 0, -1, -1);
    vectors++;
    if (err_first !== 1'b0 || obs_done.size() != 1) begin
      miscompares++; $display("FAIL timeout_clear: err=%0b dones=%0d want 0/1", err_first, obs_done.size());
    end
  endtask
`else
  task automatic test_no_timeout();
    cfg(32'd77, 32'd1, 2, 0);
    observe(40, 10000, -1, -1);
    vectors++;
    if (!obs_timeout || obs_abort.size() != 0 || err_last !== 1'b0 || bus.meas_req !== 1'b1) begin
      miscompares++;
      $display("FAIL meas_wait: still_waiting=%0b aborts=%0d err=%0b req=%0b want 1/0/0/1",
               obs_timeout, obs_abort.size(), err_last, bus.meas_req);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    vectors++;
    if (bus.aborted !== 1'b1 || bus.meas_req !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL meas_abort: abt=%0b req=%0b busy=%0b want 1/0/0", bus.aborted, bus.meas_req, bus.busy);
    end
    tick();
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.meas_ack = 1'b0;
    cfg('0, '0, 0, 0);
    test_reset();
    test_basic();
    test_zero_points();
    test_wrap();
    test_abort_restart();
    test_midsweep_ignore();
    test_start_abort_idle();
    test_reset_midsweep();
`ifdef SWEEP_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sweep_sequencer.md
Name: sweep_sequencer

Overview:
- Frequency-sweep controller for the frequency response detector.
- Steps the DDS frequency word through N points from a start word by a fixed step.
- At each point it waits a programmable settle time, then handshakes with the magnitude/phase measurement block before advancing.
- Sits between the host register file (config, start/abort) and the DDS/DRG frequency input and the detector.

Parameters:
- FWORD_W, 32, width of frequency word and step.
- NPTS_W, 16, width of point count and point index.
- SETTLE_W, 24, width of settle-cycle count.
- TIMEOUT_CYCLES, 32'd1200000, measurement ack timeout in clk cycles; used only with SWEEP_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, synchronous, active-low.
- start  in  1  sweep start request, level sampled each cycle.
- abort  in  1  sweep abort request, level sampled each cycle.
- f_start  in  FWORD_W  first frequency word.
- f_step  in  FWORD_W  per-point increment.
- n_points  in  NPTS_W  number of points.
- settle_cycles  in  SETTLE_W  settle wait per point.
- meas_ack  in  1  measurement complete from detector.
- fword  out  FWORD_W  current frequency word to DDS.
- fword_wen  out  1  one-cycle strobe when fword changes.
- meas_req  out  1  measurement request, level.
- point_idx  out  NPTS_W  index of current point.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on abort or timeout.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset: all outputs 0; state IDLE; shadow registers 0.
- States: IDLE, SETTLE, MEAS, DONE.
- IDLE, start=1 at edge T:
  - Latch f_start, f_step, n_points and settle_cycles into shadow registers. Later changes to the config inputs have no effect until the next start.
  - If n_points==0: go to DONE. No fword_wen, busy stays 0, done pulses at T+1, and the sequencer returns to IDLE.
  - Otherwise at T+1: fword=f_start, fword_wen=1, point_idx=0, busy=1, cnt=settle_cycles, state SETTLE.
- SETTLE:
  - Each cycle: if cnt==0, next state MEAS with meas_req=1; otherwise cnt decrements.
  - meas_req therefore rises settle_cycles+1 cycles after fword_wen.
- MEAS:
  - meas_req is held high until meas_ack is sampled high.
  - On ack, meas_req drops at the same edge.
  - If point_idx==n_points-1: state DONE.
  - Otherwise: fword=fword+f_step modulo 2^FWORD_W (wrap, no saturation), point_idx+1, fword_wen=1, cnt reloaded, state SETTLE.
  - meas_ack outside MEAS is ignored.
- DONE: done=1 for one cycle, busy=0, return to IDLE. fword and point_idx keep their last values.
- start while busy: ignored.
- abort in any non-IDLE state:
  - At the next edge: state IDLE, meas_req=0, busy=0, aborted=1 for one cycle, done not asserted.
  - abort has priority over meas_ack and over SETTLE expiry in the same cycle.
  - abort in IDLE is ignored, including when start and abort are high together in IDLE.
- Reset mid-sweep: immediate return to reset values, no done/aborted pulse.
- fword_wen and done never assert in the same cycle.

Optional Feature:
- Macro SWEEP_TIMEOUT_EN.
- Enabled:
  - A counter runs while in MEAS and is cleared on entry to MEAS.
  - If TIMEOUT_CYCLES elapse with no ack, the sweep terminates exactly like an abort (aborted pulse), and err is set.
  - err is cleared only by reset or by the next accepted start.
- Disabled: MEAS waits indefinitely; err is tied 0; no timeout counter is synthesized.

Test Plan:
- f_start=1000, f_step=250, n_points=4, settle_cycles=3, ack 2 cycles after each req -> fword 1000,1250,1500,1750 with 4 fword_wen strobes; each meas_req rises 4 cycles after its strobe; single done after the 4th ack; busy falls with done.
- n_points=0, start -> done pulse at T+1, no fword_wen, no meas_req, busy stays 0.
- f_start=32'hFFFFFF00, f_step=32'h100, n_points=2, settle_cycles=0 -> second fword=0 (wrap); meas_req on the cycle after each strobe.
- Abort asserted in the same cycle as meas_ack on point 1 of 3 -> aborted pulse, no further fword_wen, no done, meas_req low next cycle; re-start with the same config runs from point 0.
- Change f_step and pulse start mid-sweep -> ignored; the sweep completes with the original step values.
- With SWEEP_TIMEOUT_EN and TIMEOUT_CYCLES=16, never ack -> aborted pulse and err=1 after 16 MEAS cycles; next start clears err.
